// File: rtl/fifo_pkg.sv
// Gray/binary conversion helpers shared by the async FIFO pointer controllers.
// Functions operate on GRAY_MAX_W bits; callers zero-extend narrower pointers.
// Zero-extension leaves both conversions unchanged, so any width up to the maximum works.
package fifo_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above its position.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_empty_ctrl_ptr_sync.sv
// Generic multi-bit flop synchroniser for Gray-coded pointers crossing clock domains.
// Only safe for values that change by at most one bit between samples.
module ptr_sync #(
  parameter int unsigned W      = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sync_q [STAGES];

  // Shift the incoming pointer through the stage chain; reset clears every stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rd_empty_ctrl.sv
// Read-side pointer and empty-flag controller for the async FIFO.
// Owns the read pointer, synchronises the write Gray pointer into the read
// clock and produces registered empty / almost_empty / fill count / underflow.
module rd_empty_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned AE_THRESH   = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   wr_gray_async,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rd_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

  logic [PW-1:0] wq_gray;
  logic [PW-1:0] wq_bin;
  logic          rd_inc;
  logic [PW-1:0] rd_bin_d,   rd_bin_q;
  logic [PW-1:0] rd_gray_d,  rd_gray_q;
  logic [PW-1:0] rd_count_d, rd_count_q;
  logic          empty_q;
  logic          almost_empty_q;
  logic          underflow_q;

  ptr_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk_i (rd_clk),
    .rst_i (rd_rst),
    .d_i   (wr_gray_async),
    .q_o   (wq_gray)
  );

  // Next read pointer and look-ahead fill count, so the read taking the last
  // entry raises empty on the same edge.
  always_comb begin
    wq_bin     = PW'(gray2bin(GRAY_MAX_W'(wq_gray)));
    rd_inc     = rd_en & ~empty_q;
    rd_bin_d   = rd_bin_q + PW'(rd_inc);
    rd_gray_d  = PW'(bin2gray(GRAY_MAX_W'(rd_bin_d)));
    rd_count_d = wq_bin - rd_bin_d;
  end

  // Register pointers and status; empty compares all PW bits so an address
  // match with differing wrap bits reads as full, not empty.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_bin_q       <= '0;
      rd_gray_q      <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      rd_count_q     <= '0;
      underflow_q    <= 1'b0;
    end else begin
      rd_bin_q       <= rd_bin_d;
      rd_gray_q      <= rd_gray_d;
      empty_q        <= (rd_gray_d == wq_gray);
      almost_empty_q <= (rd_count_d <= AE_LIMIT);
      rd_count_q     <= rd_count_d;
      underflow_q    <= rd_en & empty_q;
    end
  end

  assign rd_addr      = rd_bin_q[ADDR_WIDTH-1:0];
  assign rd_gray      = rd_gray_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign rd_count     = rd_count_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_rd_empty_ctrl.sv
// Self-checking bench for rd_empty_ctrl: directed phases plus random traffic
// compared against a transaction-count reference model.
module tb_rd_empty_ctrl;

  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int AE    = 2;
  localparam int SS    = 2;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          rd_en;
  logic [PW-1:0] wr_gray_async;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_gray;
  logic          empty;
  logic          almost_empty;
  logic [PW-1:0] rd_count;
  logic          underflow;

  always #5 rd_clk = ~rd_clk;

  rd_empty_ctrl #(
    .ADDR_WIDTH  (AW),
    .AE_THRESH   (AE),
    .SYNC_STAGES (SS)
  ) dut (
    .rd_clk        (rd_clk),
    .rd_rst        (rd_rst),
    .rd_en         (rd_en),
    .wr_gray_async (wr_gray_async),
    .rd_addr       (rd_addr),
    .rd_gray       (rd_gray),
    .empty         (empty),
    .almost_empty  (almost_empty),
    .rd_count      (rd_count),
    .underflow     (underflow)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: total entries written / read since reset, and the
  // history of write totals presented at each edge.
  int wr_total;
  int rd_total;
  int hist[$];
  bit m_empty;
  bit m_ae;
  bit m_uf;
  int m_count;
  logic [PW-1:0] prev_gray;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] to_gray(input int v);
    logic [PW-1:0] b;
    b = PW'(v % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    wr_total  = 0;
    rd_total  = 0;
    hist.delete();
    m_empty   = 1'b1;
    m_ae      = 1'b1;
    m_uf      = 1'b0;
    m_count   = 0;
    prev_gray = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_empty"}, int'(empty), 1);
    check_eq({tag, "_ae"},    int'(almost_empty), 1);
    check_eq({tag, "_count"}, int'(rd_count), 0);
    check_eq({tag, "_gray"},  int'(rd_gray), 0);
    check_eq({tag, "_addr"},  int'(rd_addr), 0);
    check_eq({tag, "_uf"},    int'(underflow), 0);
  endtask

  // One read-clock cycle: drive inputs, advance the model, sample after the edge.
  task automatic step(input bit rd, input bit wr);
    int wq;
    int ones;
    if (wr && (wr_total - rd_total) < DEPTH) wr_total++;
    wr_gray_async = to_gray(wr_total);
    rd_en         = rd;
    hist.push_back(wr_total);
    // Write total becomes visible SS edges after it was first sampled.
    wq = (hist.size() > SS) ? hist[hist.size() - 1 - SS] : 0;
    m_uf = rd && m_empty;
    if (rd && !m_empty) rd_total++;
    m_count = wq - rd_total;
    m_empty = (m_count == 0);
    m_ae    = (m_count <= AE);
    @(posedge rd_clk);
    #1;
    check_eq("empty",     int'(empty),        int'(m_empty));
    check_eq("alm_empty", int'(almost_empty), int'(m_ae));
    check_eq("rd_count",  int'(rd_count),     m_count);
    check_eq("underflow", int'(underflow),    int'(m_uf));
    check_eq("rd_addr",   int'(rd_addr),      rd_total % DEPTH);
    check_eq("rd_gray",   int'(rd_gray),      int'(to_gray(rd_total)));
    ones = $countones(rd_gray ^ prev_gray);
    check_eq("gray_1bit", (ones > 1) ? 1 : 0, 0);
    prev_gray = rd_gray;
  endtask

  initial begin
    bit saw16;
    bit reached;
    model_reset();
    rd_rst        = 1'b1;
    rd_en         = 1'b0;
    wr_gray_async = '0;
    #12;
    check_reset_vals("por");
    @(negedge rd_clk);
    rd_rst = 1'b0;

    // Idle after reset: nothing may change.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

    // Write pointer jumps 0 -> 3: visible on the third edge.
    wr_total = 3;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("lat_still_empty", int'(empty), 1);
    step(1'b0, 1'b0);
    check_eq("lat_count3", int'(rd_count), 3);
    check_eq("lat_not_ae", int'(almost_empty), 0);

    // Drain three entries.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    check_eq("drain_empty", int'(empty), 1);

    // Reads while empty.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
    check_eq("uf_gray_hold", int'(rd_gray), int'(to_gray(3)));

    // Fill to depth, then stream reads and writes through the wrap point.
    saw16 = 1'b0;
    for (int i = 0; i < 22; i++) begin
      step(1'b0, 1'b1);
      if (m_count == DEPTH) saw16 = 1'b1;
    end
    check_eq("full16_seen", int'(saw16), 1);
    check_eq("full16_not_empty", int'(empty), 0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 22; i++) step(1'b1, 1'b0);
    check_eq("wrap_passed", (rd_total >= 2 * DEPTH) ? 1 : 0, 1);

    // Random traffic with varying read/write bias.
    for (int i = 0; i < 400; i++) begin
      int rp, wp;
      rp = (i < 200) ? 40 : 70;
      wp = (i < 200) ? 70 : 40;
      step($urandom_range(0, 99) < rp, $urandom_range(0, 99) < wp);
    end

    // Drain, then build a count of exactly 5 and reset asynchronously.
    for (int i = 0; i < 24; i++) step(1'b1, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      step(1'b0, (wr_total - rd_total) < 5);
      if (m_count == 5) reached = 1'b1;
    end
    check_eq("count5_reached", int'(reached), 1);
    #2;
    rd_rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    model_reset();
    wr_gray_async = '0;
    @(negedge rd_clk);
    rd_rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 80; i++) step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rd_empty_ctrl.md
# rd_empty_ctrl

Read-side pointer and empty-flag controller for the async FIFO, generalising the combinational empty compare into a registered, parametrised block. Owns the read pointer (binary and Gray), synchronises the write-domain Gray pointer into the read clock, and produces registered `empty`, programmable `almost_empty`, a read-side fill count and an underflow pulse. Sits entirely in the read clock domain between the FIFO memory read port and the consumer.

## Interface

Parameters:
- `ADDR_WIDTH`, 4: memory address width; depth = 2^ADDR_WIDTH; pointer width PW = ADDR_WIDTH+1.
- `AE_THRESH`, 2: `almost_empty` asserts when fill count ≤ AE_THRESH; legal range 0..2^ADDR_WIDTH-1.
- `SYNC_STAGES`, 2: flop stages on the incoming write pointer; legal ≥ 2.

Ports:
- `rd_clk`  in  1  read clock; all state on rising edge.
- `rd_rst`  in  1  asynchronous, active-high reset.
- `rd_en`  in  1  consumer read request.
- `wr_gray_async`  in  PW  write-domain Gray pointer, unsynchronised.
- `rd_addr`  out  ADDR_WIDTH  memory read address (low bits of binary read pointer).
- `rd_gray`  out  PW  registered Gray read pointer, for export to the write domain.
- `empty`  out  1  registered empty flag.
- `almost_empty`  out  1  registered, count ≤ AE_THRESH.
- `rd_count`  out  PW  registered fill count as seen from the read domain, 0..2^ADDR_WIDTH.
- `underflow`  out  1  one-cycle pulse: `rd_en` while `empty`.

## Operation

- Synchroniser: `wr_gray_async` passes through SYNC_STAGES flops; last stage is `wq_gray`. `wq_bin` = Gray-to-binary of `wq_gray` (combinational).
- `rd_inc` = `rd_en & ~empty`. Read while empty is ignored: pointer holds and `underflow` pulses next cycle.
- `rd_bin_next` = `rd_bin + rd_inc`, modulo 2^PW (natural wrap, MSB toggles each pass).
- `rd_gray_next` = `rd_bin_next ^ (rd_bin_next >> 1)`.
- Registered each edge: `rd_bin ← rd_bin_next`, `rd_gray ← rd_gray_next`, `empty ← (rd_gray_next == wq_gray)`, `rd_count ← (wq_bin − rd_bin_next) mod 2^PW`, `almost_empty ← (that count ≤ AE_THRESH)`, `underflow ← rd_en & empty`.
- Look-ahead: the read that consumes the last entry sets `empty` on the same edge; no extra bubble.
- `rd_addr` = `rd_bin[ADDR_WIDTH-1:0]`; data for the read presented to memory is at the address held before the edge.
- Reset (async assert, any time incl. mid-transfer): `rd_bin`=0, `rd_gray`=0, all sync stages 0, `empty`=1, `almost_empty`=1, `rd_count`=0, `underflow`=0. Write side is reset together; no partial-reset recovery required.

## Timing

- Write-pointer change on `wr_gray_async` (held stable) → visible in `wq_gray` after SYNC_STAGES `rd_clk` edges → `empty`/`rd_count`/`almost_empty` update on the next edge: SYNC_STAGES+1 edges total.
- Read → pointers, `empty`, count update on the same edge (latency 1).
- Simultaneous read and new synchronised write: both reflected in one update; count = new `wq_bin` − new `rd_bin`.
- `rd_count` is pessimistic (never over-reports); it may lag writes by the sync latency.
- Wrap-around: empty compares full PW bits, so pointers equal in address but differing in MSB are not empty.

## Structure

- Shared package `fifo_pkg`: `bin2gray` / `gray2bin` functions parametrised by width; no other typedefs.
- One sub-module: `ptr_sync` (generic SYNC_STAGES-deep multi-bit flop synchroniser, async active-high reset to 0); reused by the write-side full controller.
- Rest is flat in `rd_empty_ctrl`, ~150 lines.

## Test plan

- Reset: assert `rd_rst` mid-cycle → immediately `empty`=1, `almost_empty`=1, `rd_count`=0, `rd_gray`=0; hold after release with no writes.
- Write latency: ADDR_WIDTH=4, SYNC_STAGES=2, `wr_gray_async` 0→2 (binary 3) → `empty` falls and `rd_count`=3 on 3rd edge; `almost_empty` stays 0 (3 > 2).
- Drain: 3 consecutive `rd_en` → `rd_count` 2,1,0; `almost_empty` rises after first read; `empty` rises on 3rd read edge; `rd_addr` 0,1,2.
- Underflow: `rd_en`=1 while empty for 2 cycles → pointer unchanged, `underflow` high 2 cycles, `rd_gray` stable.
- Wrap: stream 40 writes/reads with depth 16 → `rd_bin` wraps past 31 to 0, `rd_gray` changes one bit per read, no false empty at address match with MSB difference (`rd_count`=16 case).
- Reset mid-operation with `rd_count`=5 → all outputs return to reset values asynchronously, resume correctly after new writes.
